riscv_muldiv_unit: RTL
======================

// Module: riscv_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit beside the single-cycle ALU in EX. It executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
//  - Both sides use a valid/ready handshake.
//  - The unit processes one operation at a time and stalls the pipeline while it is busy.
//  - A tag (destination rd) travels with each operation so writeback can be routed correctly.
// PARAMETERS
//  XLEN    32  operand/result width; must be even and >= 8
//  UNROLL  1   radix-2 iterations per cycle (1, 2 or 4); must divide XLEN
//  TAG_W   5   width of the passthrough tag
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       abort the current operation (mispredict/trap)
//  in_valid   in   1       operation request
//  in_ready   out  1       unit can accept; high only in IDLE
//  in_funct3  in   3       muldiv_op_t (M-extension funct3)
//  in_a       in   XLEN    rs1 value
//  in_b       in   XLEN    rs2 value
//  in_tag     in   TAG_W   rd index; returned unchanged on out_tag
//  out_valid  out  1       result available; high only in DONE
//  out_ready  in   1       consumer takes the result
//  out_result out  XLEN    result
//  out_tag    out  TAG_W   tag of the result
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, iteration counter=0.
//  - FSM states: IDLE, CALC, DONE. Transitions:
//    - IDLE->CALC on in_valid && in_ready && !flush. The unit latches funct3, tag, |a| and |b| (absolute values per signedness), and the result sign; count = XLEN/UNROLL.
//    - IDLE->DONE on the same accept when the operation is special: divisor==0, or signed overflow (DIV/REM with a = -2^(XLEN-1) and b = -1). The result is then registered directly.
//    - CALC: each cycle performs UNROLL shift-add (mul) or restoring shift-subtract (div) steps and decrements count.
//    - CALC->DONE when count reaches 0. On this transition the unit applies sign correction and selects the high/low product or the quotient/remainder into out_result.
//    - DONE->IDLE on out_ready. out_result and out_tag hold stable while out_valid && !out_ready.
//  - flush: from any state the unit goes to IDLE on the next edge and out_valid drops. If flush and in_valid occur in the same cycle, flush wins and nothing is accepted.
//  - Latency (accept edge to out_valid high):
//    - normal operation: XLEN/UNROLL + 1 cycles
//    - special cases: 1 cycle
//  - Throughput: at most one operation per XLEN/UNROLL + 2 cycles. There is no overlap, so in_ready=0 in CALC and DONE.
//  - Arithmetic (results mod 2^XLEN):
//    - MUL returns the low XLEN bits of the 2*XLEN product.
//    - MULH, MULHSU and MULHU return the high XLEN bits of the product for signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
//    - DIV/DIVU round the quotient toward zero. REM/REMU take the sign of the dividend.
//    - Divide by zero: quotient = all ones; remainder = a.
//    - Signed overflow: DIV = -2^(XLEN-1); REM = 0.
//  - Internal width: the product/remainder accumulator is 2*XLEN+1 bits. No other widths are widened.
//  - A funct3 outside muldiv_op_t cannot occur (all 8 codes are legal).
// STRUCTURE
//  - Shared package riscv_pkg gains:
//    - muldiv_op_t enum (F3_MUL=000, F3_MULH=001, F3_MULHSU=010, F3_MULHU=011, F3_DIV=100, F3_DIVU=101, F3_REM=110, F3_REMU=111)
//    - F7_MULDIV = 7'b0000001
//    - muldiv_state_t {MD_IDLE, MD_CALC, MD_DONE}
//  - One combinational sub-module, riscv_muldiv_step. It performs a single radix-2 mul-add or div-subtract step and is instantiated UNROLL times in a generate chain.
// TESTING
//  T1 MUL a=7, b=-3 -> out_result=0xFFFFFFEB, out_valid exactly 33 cycles after accept (UNROLL=1).
//  T2 MULHU a=b=0xFFFFFFFF -> out_result=0xFFFFFFFE. MULH on the same operands -> 0x00000000. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
//  T3 DIV a=-7, b=2 -> quotient -3 (0xFFFFFFFD). REM on the same operands -> -1 (0xFFFFFFFF). DIVU a=100, b=7 -> 14; REMU -> 2.
//  T4 Special cases, each with out_valid 1 cycle after accept:
//     - DIV a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5
//     - DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0
//  T5 Backpressure: hold out_ready=0 for 10 cycles in DONE -> result, tag and out_valid stay stable and in_ready=0. Release -> IDLE next cycle and in_ready=1.
//  T6 Flush: assert flush 5 cycles into CALC -> IDLE next edge and out_valid never rises. Then DIVU 9/3 issued in the same cycle as a second flush -> not accepted; retry -> result 3, tag preserved.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension funct3 codes and the mul/div FSM states,
// plus small decode helpers for operand signedness.
package riscv_pkg;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } muldiv_op_t;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_CALC = 2'b01,
      MD_DONE = 2'b10
   } muldiv_state_t;

   function automatic logic md_is_div(input muldiv_op_t op);
      case (op)
         F3_DIV, F3_DIVU, F3_REM, F3_REMU: md_is_div = 1'b1;
         default:                          md_is_div = 1'b0;
      endcase
   endfunction

   function automatic logic md_a_signed(input muldiv_op_t op);
      case (op)
         F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: md_a_signed = 1'b1;
         default:                                    md_a_signed = 1'b0;
      endcase
   endfunction

   function automatic logic md_b_signed(input muldiv_op_t op);
      case (op)
         F3_MUL, F3_MULH, F3_DIV, F3_REM: md_b_signed = 1'b1;
         default:                         md_b_signed = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/riscv_muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add for multiply,
// restoring shift-subtract for divide. Accumulator is {hi[XLEN:0], lo[XLEN-1:0]}.
module riscv_muldiv_step
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              is_div,
   input  logic [XLEN-1:0]   operand,
   input  logic [2*XLEN:0]   acc_in,
   output logic [2*XLEN:0]   acc_out
);

   logic [2*XLEN:0] shl_s;
   logic [XLEN:0]   sum_s;

   // Single iteration; hi half never overflows because the magnitudes fit XLEN bits.
   always_comb begin
      shl_s   = {acc_in[2*XLEN-1:0], 1'b0};
      sum_s   = acc_in[2*XLEN:XLEN];
      acc_out = acc_in;
      if (is_div) begin
         if (shl_s[2*XLEN:XLEN] >= {1'b0, operand}) begin
            acc_out = {shl_s[2*XLEN:XLEN] - {1'b0, operand}, shl_s[XLEN-1:1], 1'b1};
         end else begin
            acc_out = shl_s;
         end
      end else begin
         if (acc_in[0]) begin
            sum_s = acc_in[2*XLEN:XLEN] + {1'b0, operand};
         end else begin
            sum_s = acc_in[2*XLEN:XLEN];
         end
         acc_out = {1'b0, sum_s, acc_in[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready on both sides; one
// operation in flight, UNROLL radix-2 steps per cycle, sign fix-up at the end.
module riscv_muldiv_unit
   import riscv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int STEPS = XLEN / UNROLL;
   localparam int CNT_W = $clog2(STEPS + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};
   localparam logic [XLEN-1:0]  ONES_X   = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]  MIN_X    = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t     state_r, state_nxt_s;
   muldiv_op_t        op_r, op_nxt_s, op_in_s;
   logic [TAG_W-1:0]  tag_r, tag_nxt_s;
   logic [XLEN-1:0]   operand_r, operand_nxt_s;
   logic [2*XLEN:0]   acc_r, acc_nxt_s, step_acc_s;
   logic [CNT_W-1:0]  count_r, count_nxt_s;
   logic              neg_r, neg_nxt_s;
   logic [XLEN-1:0]   result_r, result_nxt_s;
   logic              in_ready_r, out_valid_r;

   logic              a_neg_s, b_neg_s, neg_in_s;
   logic [XLEN-1:0]   a_mag_s, b_mag_s, special_res_s;
   logic              div_zero_s, ovf_s, special_s;
   logic [2*XLEN-1:0] prod_s, prod_fix_s;
   logic [XLEN-1:0]   quot_fix_s, rem_fix_s, final_s;

   // Unrolled datapath: stage g feeds stage g+1 within one clock.
   for (genvar g = 0; g < UNROLL; g++) begin : g_step
      logic [2*XLEN:0] stage_in_s;
      logic [2*XLEN:0] stage_out_s;
      if (g == 0) begin : g_first
         assign stage_in_s = acc_r;
      end else begin : g_next
         assign stage_in_s = g_step[g-1].stage_out_s;
      end
      riscv_muldiv_step #(.XLEN(XLEN)) u_step (
         .is_div  (md_is_div(op_r)),
         .operand (operand_r),
         .acc_in  (stage_in_s),
         .acc_out (stage_out_s)
      );
   end
   assign step_acc_s = g_step[UNROLL-1].stage_out_s;

   // Request decode: magnitudes, result sign and the two short-circuit cases.
   always_comb begin
      op_in_s    = muldiv_op_t'(in_funct3);
      a_neg_s    = md_a_signed(op_in_s) & in_a[XLEN-1];
      b_neg_s    = md_b_signed(op_in_s) & in_b[XLEN-1];
      if (a_neg_s) begin
         a_mag_s = -in_a;
      end else begin
         a_mag_s = in_a;
      end
      if (b_neg_s) begin
         b_mag_s = -in_b;
      end else begin
         b_mag_s = in_b;
      end
      div_zero_s = (in_b == ZERO_X);
      ovf_s      = ((op_in_s == F3_DIV) || (op_in_s == F3_REM)) &&
                   (in_a == MIN_X) && (in_b == ONES_X);
      special_s  = md_is_div(op_in_s) && (div_zero_s || ovf_s);
      case (op_in_s)
         F3_DIV, F3_DIVU: special_res_s = div_zero_s ? ONES_X : MIN_X;
         F3_REM, F3_REMU: special_res_s = div_zero_s ? in_a : ZERO_X;
         default:         special_res_s = ZERO_X;
      endcase
      // Remainder follows the dividend; everything else is the xor of signs.
      if ((op_in_s == F3_REM) || (op_in_s == F3_REMU)) begin
         neg_in_s = a_neg_s;
      end else begin
         neg_in_s = a_neg_s ^ b_neg_s;
      end
   end

   // Sign correction and result selection from the last step's output.
   always_comb begin
      prod_s = step_acc_s[2*XLEN-1:0];
      if (neg_r) begin
         prod_fix_s = -prod_s;
         quot_fix_s = -step_acc_s[XLEN-1:0];
         rem_fix_s  = -step_acc_s[2*XLEN-1:XLEN];
      end else begin
         prod_fix_s = prod_s;
         quot_fix_s = step_acc_s[XLEN-1:0];
         rem_fix_s  = step_acc_s[2*XLEN-1:XLEN];
      end
      case (op_r)
         F3_MUL:                       final_s = prod_fix_s[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: final_s = prod_fix_s[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              final_s = quot_fix_s;
         F3_REM, F3_REMU:              final_s = rem_fix_s;
         default:                      final_s = ZERO_X;
      endcase
   end

   // Next-state and datapath-load logic; flush overrides everything.
   always_comb begin
      state_nxt_s   = state_r;
      op_nxt_s      = op_r;
      tag_nxt_s     = tag_r;
      operand_nxt_s = operand_r;
      acc_nxt_s     = acc_r;
      count_nxt_s   = count_r;
      neg_nxt_s     = neg_r;
      result_nxt_s  = result_r;
      case (state_r)
         MD_IDLE: begin
            if (flush) begin
               state_nxt_s = MD_IDLE;
            end else if (in_valid) begin
               op_nxt_s      = op_in_s;
               tag_nxt_s     = in_tag;
               operand_nxt_s = b_mag_s;
               acc_nxt_s     = {{(XLEN+1){1'b0}}, a_mag_s};
               neg_nxt_s     = neg_in_s;
               if (special_s) begin
                  result_nxt_s = special_res_s;
                  count_nxt_s  = CNT_ZERO;
                  state_nxt_s  = MD_DONE;
               end else begin
                  count_nxt_s  = CNT_INIT;
                  state_nxt_s  = MD_CALC;
               end
            end else begin
               state_nxt_s = MD_IDLE;
            end
         end
         MD_CALC: begin
            if (flush) begin
               count_nxt_s = CNT_ZERO;
               state_nxt_s = MD_IDLE;
            end else begin
               acc_nxt_s   = step_acc_s;
               count_nxt_s = count_r - CNT_ONE;
               if (count_r == CNT_ONE) begin
                  result_nxt_s = final_s;
                  state_nxt_s  = MD_DONE;
               end else begin
                  state_nxt_s  = MD_CALC;
               end
            end
         end
         MD_DONE: begin
            if (flush || out_ready) begin
               state_nxt_s = MD_IDLE;
            end else begin
               state_nxt_s = MD_DONE;
            end
         end
         default: begin
            state_nxt_s = MD_IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= MD_IDLE;
         op_r        <= F3_MUL;
         tag_r       <= {TAG_W{1'b0}};
         operand_r   <= ZERO_X;
         acc_r       <= {(2*XLEN+1){1'b0}};
         count_r     <= CNT_ZERO;
         neg_r       <= 1'b0;
         result_r    <= ZERO_X;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         op_r        <= op_nxt_s;
         tag_r       <= tag_nxt_s;
         operand_r   <= operand_nxt_s;
         acc_r       <= acc_nxt_s;
         count_r     <= count_nxt_s;
         neg_r       <= neg_nxt_s;
         result_r    <= result_nxt_s;
         in_ready_r  <= (state_nxt_s == MD_IDLE);
         out_valid_r <= (state_nxt_s == MD_DONE);
      end
   end

   assign in_ready   = in_ready_r;
   assign out_valid  = out_valid_r;
   assign out_result = result_r;
   assign out_tag    = tag_r;

endmodule
